// File: rtl/lif_neuron_cascade.sv
// Cascade of NUM_STAGES leaky integrate-and-fire neurons with leak, refractory hold and per-stage spike pulses.
// Optional last-stage spike counter is built only when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_cascade #(
  parameter int DATA_W      = 8,
  parameter int NUM_STAGES  = 2,
  parameter int LEAK_SHIFT  = 1,
  parameter int THRESHOLD   = 200,
  parameter int REFRACT_CYC = 4,
  parameter int WEIGHT      = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_W-1:0]     i_syn,
  output logic [DATA_W-1:0]     v_mem_out,
  output logic [NUM_STAGES-1:0] spike_out,
  output logic [15:0]           spike_cnt
);

  localparam int                SUM_W    = DATA_W + 1;
  localparam logic [SUM_W-1:0]  V_MAX    = {1'b0, {DATA_W{1'b1}}};
  localparam logic [SUM_W-1:0]  THR      = SUM_W'(THRESHOLD);
  // A threshold above the largest storable membrane value turns firing off entirely.
  localparam bit                FIRE_EN  = (THRESHOLD <= ((2 ** DATA_W) - 1));
  localparam logic [7:0]        REFRACT  = 8'(REFRACT_CYC);
  localparam logic [DATA_W-1:0] WEIGHT_V = DATA_W'(WEIGHT);

  logic [DATA_W-1:0]     v_q    [NUM_STAGES];
  logic [DATA_W-1:0]     v_d    [NUM_STAGES];
  logic [7:0]            r_q    [NUM_STAGES];
  logic [7:0]            r_d    [NUM_STAGES];
  logic [NUM_STAGES-1:0] spike_q;
  logic [NUM_STAGES-1:0] spike_d;
  logic [DATA_W-1:0]     in_w   [NUM_STAGES];
  logic [DATA_W-1:0]     leak_w [NUM_STAGES];
  logic [SUM_W-1:0]      sum_w  [NUM_STAGES];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign in_w[k] = i_syn;
    end else begin : g_next
      // Registered spike of the previous stage: one cycle of latency per stage.
      assign in_w[k] = spike_q[k-1] ? WEIGHT_V : '0;
    end
    assign leak_w[k] = v_q[k] - (v_q[k] >> LEAK_SHIFT);
    assign sum_w[k]  = {1'b0, leak_w[k]} + {1'b0, in_w[k]};
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      v_d[k]     = v_q[k];
      r_d[k]     = r_q[k];
      spike_d[k] = 1'b0;
      if (en) begin
        if (r_q[k] != 8'd0) begin
          v_d[k] = '0;
          r_d[k] = r_q[k] - 8'd1;
        end else if (FIRE_EN && (sum_w[k] >= THR)) begin
          spike_d[k] = 1'b1;
          v_d[k]     = '0;
          r_d[k]     = REFRACT;
        end else if (sum_w[k] > V_MAX) begin
          v_d[k] = '1;
        end else begin
          v_d[k] = sum_w[k][DATA_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        v_q[k] <= '0;
        r_q[k] <= '0;
      end
      spike_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        v_q[k] <= v_d[k];
        r_q[k] <= r_d[k];
      end
      spike_q <= spike_d;
    end
  end

  assign v_mem_out = v_q[NUM_STAGES-1];
  assign spike_out = spike_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (spike_d[NUM_STAGES-1] && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign spike_cnt = cnt_q;
`else
  assign spike_cnt = 16'h0000;
`endif

endmodule
